// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer: op encoding, FSM states, op-class helper.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    localparam int MD_CNT_W = 4;

    // True for the multi-cycle ops (MULT/MULTU/DIV/DIVU) that occupy the unit.
    function automatic logic OP_IS_MULDIV(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
module md_result_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_pend_hi,
    output logic [31:0] o_pend_lo,
    output logic        o_div_zero
);

    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_b_zero;

    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);

    // The low 64 bits of a 64x64 product of extended operands are the exact 32x32 result.
    assign w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
    assign w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg   = w_signed & i_a[31];
    assign w_b_neg   = w_signed & i_b[31];
    assign w_a_mag   = w_a_neg ? -i_a : i_a;
    assign w_b_mag   = w_b_neg ? -i_b : i_b;
    assign w_b_zero  = (i_b == 32'd0);
    assign w_divisor = w_b_zero ? 32'd1 : w_b_mag;
    assign w_uq      = w_a_mag / w_divisor;
    assign w_ur      = w_a_mag % w_divisor;
    assign w_q       = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_r       = w_a_neg ? -w_ur : w_ur;

    always_comb begin
        o_pend_hi  = 32'd0;
        o_pend_lo  = 32'd0;
        o_div_zero = 1'b0;
        case (i_op)
            OP_MULT, OP_MULTU: begin
                o_pend_hi = w_prod[63:32];
                o_pend_lo = w_prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                o_pend_hi  = w_r;
                o_pend_lo  = w_q;
                o_div_zero = w_b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MD sequencer owning HI/LO with fixed-latency counter FSM and Decode stall.
// Optional MD_ABORT_EN adds an i_abort input that cancels an in-flight operation.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_d_is_md,
`ifdef MD_ABORT_EN
    input  logic        i_abort,
`endif
    output logic        o_busy,
    output logic        o_stall_d,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

    md_state_t           r_state;
    logic [MD_CNT_W-1:0] r_cnt;
    logic                r_busy;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_pend_hi;
    logic [31:0]         r_pend_lo;
    logic                r_pend_dz;

    logic [31:0] w_pend_hi;
    logic [31:0] w_pend_lo;
    logic        w_div_zero;

    md_result_calc u_calc (
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_pend_hi  (w_pend_hi),
        .o_pend_lo  (w_pend_lo),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
        end else begin
`ifdef MD_ABORT_EN
            if (i_abort) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_busy    <= 1'b0;
                r_pend_hi <= 32'd0;
                r_pend_lo <= 32'd0;
                r_pend_dz <= 1'b0;
            end else
`endif
            begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            case (i_op)
                                OP_MULT, OP_MULTU: begin
                                    r_state   <= MUL;
                                    r_cnt     <= MUL_LOAD;
                                    r_busy    <= 1'b1;
                                    r_pend_hi <= w_pend_hi;
                                    r_pend_lo <= w_pend_lo;
                                    r_pend_dz <= 1'b0;
                                end
                                OP_DIV, OP_DIVU: begin
                                    r_state   <= DIV;
                                    r_cnt     <= DIV_LOAD;
                                    r_busy    <= 1'b1;
                                    r_pend_hi <= w_pend_hi;
                                    r_pend_lo <= w_pend_lo;
                                    r_pend_dz <= w_div_zero;
                                end
                                OP_MTHI: r_hi <= i_a;
                                OP_MTLO: r_lo <= i_a;
                                default: ;
                            endcase
                        end
                    end
                    MUL, DIV: begin
                        // Divide-by-zero still burns the full latency but leaves HI/LO alone.
                        if (r_cnt == '0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (!r_pend_dz) begin
                                r_hi <= r_pend_hi;
                                r_lo <= r_pend_lo;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
    assign o_stall_d = i_d_is_md & (r_busy | (i_start & OP_IS_MULDIV(i_op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against a behavioural HI/LO model.
module tb_md_sequencer;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dIsMd;
    logic        abort = 1'b0;
    logic        oBusy;
    logic        oStallD;
    logic [31:0] oHi;
    logic [31:0] oLo;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int          mBusyLeft = 0;
    bit          mUpd = 1'b0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    longint      sProd;
    logic [63:0] uProd;
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;

    md_sequencer #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_start   (start),
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .i_d_is_md (dIsMd),
`ifdef MD_ABORT_EN
        .i_abort   (abort),
`endif
        .o_busy    (oBusy),
        .o_stall_d (oStallD),
        .o_hi      (oHi),
        .o_lo      (oLo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a count of remaining busy cycles plus the architectural result.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mBusyLeft = 0;
            mUpd = 1'b0;
            mPendHi = 32'd0;
            mPendLo = 32'd0;
            mHi = 32'd0;
            mLo = 32'd0;
        end else if (mBusyLeft > 0) begin
            if (start) begin
                checks++;
                errors++;
                $display("[TB] FAIL start_while_busy: start=1 with %0d busy cycles left", mBusyLeft);
            end
            mBusyLeft--;
            if (mBusyLeft == 0 && mUpd) begin
                mHi = mPendHi;
                mLo = mPendLo;
            end
        end else if (start) begin
            case (op)
                3'd0: begin
                    sProd = longint'($signed(a)) * longint'($signed(b));
                    mPendHi = sProd[63:32];
                    mPendLo = sProd[31:0];
                    mUpd = 1'b1;
                    mBusyLeft = MUL_N;
                end
                3'd1: begin
                    uProd = {32'd0, a} * {32'd0, b};
                    mPendHi = uProd[63:32];
                    mPendLo = uProd[31:0];
                    mUpd = 1'b1;
                    mBusyLeft = MUL_N;
                end
                3'd2: begin
                    mUpd = (b != 32'd0);
                    if (b != 32'd0) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        sq = sa / sb;
                        sr = sa % sb;
                        mPendLo = sq[31:0];
                        mPendHi = sr[31:0];
                    end
                    mBusyLeft = DIV_N;
                end
                3'd3: begin
                    mUpd = (b != 32'd0);
                    if (b != 32'd0) begin
                        mPendLo = a / b;
                        mPendHi = a % b;
                    end
                    mBusyLeft = DIV_N;
                end
                3'd4: mHi = a;
                3'd5: mLo = a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            logic expBusy;
            logic expStall;
            expBusy = (mBusyLeft > 0);
            expStall = dIsMd & (expBusy | (start & (op <= 3'd3)));
            checkOutput("busy", {31'd0, oBusy}, {31'd0, expBusy});
            checkOutput("stall_d", {31'd0, oStallD}, {31'd0, expStall});
            checkOutput("hi", oHi, mHi);
            checkOutput("lo", oLo, mLo);
        end
    end

    function automatic logic pickMd(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from an idle unit; returns the busy/stall cycles seen on the DUT.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input int mdMode, output int busyCycles, output int stallCycles,
                                 output logic stallAtStart);
        start = 1'b1;
        op = opIn;
        a = aIn;
        b = bIn;
        dIsMd = pickMd(mdMode);
        #1 stallAtStart = oStallD;
        busyCycles = 0;
        stallCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            dIsMd = pickMd(mdMode);
            #1;
            if (!oBusy) break;
            busyCycles++;
            if (oStallD) stallCycles++;
        end
    endtask

    int   bc;
    int   sc;
    logic ss;

    initial begin
        rstN = 1'b0;
        start = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        dIsMd = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("reset_hi", oHi, 32'd0);
        checkOutput("reset_lo", oLo, 32'd0);
        rstN = 1'b1;
        checkEn = 1'b1;
        @(posedge clk);
        #2;

        applyStimulus(3'd0, 32'd3, 32'hFFFF_FFFC, 1, bc, sc, ss);
        checkOutput("T1_busy_cycles", 32'(bc), 32'd5);
        checkOutput("T1_hi", oHi, 32'hFFFF_FFFF);
        checkOutput("T1_lo", oLo, 32'hFFFF_FFF4);
        checkOutput("T5_stall_start", {31'd0, ss}, 32'd1);
        checkOutput("T5_stall_cycles", 32'(sc), 32'd5);
        checkOutput("T5_stall_after", {31'd0, oStallD}, 32'd0);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 0, bc, sc, ss);
        checkOutput("T2_busy_cycles", 32'(bc), 32'd5);
        checkOutput("T2_hi", oHi, 32'h0000_0001);
        checkOutput("T2_lo", oLo, 32'hFFFF_FFFE);
        checkOutput("T5_nostall_start", {31'd0, ss}, 32'd0);
        checkOutput("T5_nostall_cycles", 32'(sc), 32'd0);

        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 2, bc, sc, ss);
        checkOutput("T3_busy_cycles", 32'(bc), 32'd10);
        checkOutput("T3_hi", oHi, 32'hFFFF_FFFF);
        checkOutput("T3_lo", oLo, 32'hFFFF_FFFD);

        applyStimulus(3'd4, 32'h11, 32'd0, 2, bc, sc, ss);
        checkOutput("T4_mthi_busy", 32'(bc), 32'd0);
        applyStimulus(3'd5, 32'h22, 32'd0, 2, bc, sc, ss);
        checkOutput("T4_mtlo_busy", 32'(bc), 32'd0);
        checkOutput("T4_preset_hi", oHi, 32'h11);
        checkOutput("T4_preset_lo", oLo, 32'h22);
        applyStimulus(3'd3, 32'd100, 32'd0, 2, bc, sc, ss);
        checkOutput("T4_busy_cycles", 32'(bc), 32'd10);
        checkOutput("T4_hi", oHi, 32'h11);
        checkOutput("T4_lo", oLo, 32'h22);

        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2, bc, sc, ss);
        checkOutput("ovf_hi", oHi, 32'h0);
        checkOutput("ovf_lo", oLo, 32'h8000_0000);

        start = 1'b1;
        op = 3'd2;
        a = 32'd1000;
        b = 32'd7;
        dIsMd = 1'b0;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        checkOutput("T6_busy_before", {31'd0, oBusy}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("T6_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("T6_hi", oHi, 32'd0);
        checkOutput("T6_lo", oLo, 32'd0);
        @(posedge clk);
        #2 rstN = 1'b1;
        @(posedge clk);
        #2;

        for (int n = 0; n < 250; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 2, bc, sc, ss);
            checkOutput("busy_bound", {31'd0, (bc < 20)}, 32'd1);
            repeat ($urandom_range(0, 2)) begin
                start = 1'b0;
                dIsMd = pickMd(2);
                @(posedge clk);
                #2;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
